// File: rtl/pkt_tx.sv
// pkt_tx: byte-stream frame transmitter with 8b/10b-style control characters.
// A frame is /S/, a 6-byte 0x55 preamble, 0xD5 SFD, the payload (optionally
// padded), a reflected CRC-32 (LSB byte first), /T/ and one or two /R/.
// Idle alternates K28.5 / D16.2 on a free-running parity bit.
// Optional feature macro: PKT_TX_PAD_EN -- when defined, frames shorter than
// MIN_COUNT are zero-padded; when undefined, short frames are sent unpadded.
module pkt_tx #(
  parameter int MAX_COUNT = 896,
  parameter int MIN_COUNT = 60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TXD_IN,
  input  logic       TXVALID,
  input  logic       LAST,
  output logic       TXRDY,
  output logic [7:0] TXD,
  output logic       TXK,
  output logic       ERR,
  output logic       BUSY,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_PRE   = 4'd2,
    S_SFD   = 4'd3,
    S_PAY   = 4'd4,
    S_PAD   = 4'd5,
    S_CRC   = 4'd6,
    S_EOPT  = 4'd7,
    S_EXTR  = 4'd8,
    S_FLUSH = 4'd9
  } state_t;

  localparam logic [7:0]  K_IDLE   = 8'hBC;  // K28.5
  localparam logic [7:0]  D_IDLE   = 8'h50;  // D16.2
  localparam logic [7:0]  K_START  = 8'hFB;  // K27.7 /S/
  localparam logic [7:0]  B_PRE    = 8'h55;
  localparam logic [7:0]  B_SFD    = 8'hD5;
  localparam logic [7:0]  B_PAD    = 8'h00;
  localparam logic [7:0]  K_TERM   = 8'hFD;  // K29.7 /T/
  localparam logic [7:0]  K_CARR   = 8'hF7;  // K23.7 /R/
  localparam logic [7:0]  K_VIOL   = 8'hFE;  // K30.7 /V/
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [10:0] C_MAX    = 11'(MAX_COUNT);
  localparam logic [10:0] C_MIN    = 11'(MIN_COUNT);

  // One byte step of the reflected CRC-32 (poly 0x04C11DB7 reversed = 0xEDB88320).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Registered state
  state_t      r_state;
  logic        r_par;
  logic [7:0]  r_txd;
  logic        r_txk;
  logic        r_err;
  logic [10:0] r_count;
  logic [31:0] r_crc;
  logic [2:0]  r_cnt;        // preamble / CRC byte index
  logic        r_last_seen;  // LAST accepted, last byte currently on the line

  // Next-cycle values
  state_t      w_nxt;
  logic        w_par_nxt;
  logic [7:0]  w_txd_nxt;
  logic        w_txk_nxt;
  logic        w_viol;
  logic [10:0] w_count_nxt;
  logic [31:0] w_crc_nxt;
  logic [31:0] w_crc_out;
  logic [2:0]  w_cnt_nxt;
  logic        w_last_nxt;
  logic        w_rdy;
  logic        w_acc;

  assign w_par_nxt = ~r_par;
  assign w_acc     = TXVALID & w_rdy;
  assign w_crc_out = ~w_crc_nxt;

  // Ready decode: bytes are taken in Sfd, in Payload until LAST is in, and in Flush.
  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      S_SFD:   w_rdy = 1'b1;
      S_PAY:   w_rdy = ~r_last_seen;
      S_FLUSH: w_rdy = 1'b1;
      default: w_rdy = 1'b0;
    endcase
  end

  // Next-state, counter and CRC update logic.
  always_comb begin
    w_nxt       = r_state;
    w_count_nxt = r_count;
    w_crc_nxt   = r_crc;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last_seen;
    w_viol      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Only launch from an odd cycle so that /S/ lands on even parity.
        if (TXVALID && r_par) begin
          w_nxt = S_START;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      S_START: begin
        w_nxt       = S_PRE;
        w_cnt_nxt   = 3'd0;
        w_count_nxt = 11'd0;
        w_crc_nxt   = CRC_INIT;
        w_last_nxt  = 1'b0;
      end
      S_PRE: begin
        if (r_cnt == 3'd5) begin
          w_nxt = S_SFD;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_SFD, S_PAY: begin
        if (r_last_seen) begin
          // Last payload byte is on the line now; choose pad or CRC.
          w_last_nxt = 1'b0;
`ifdef PKT_TX_PAD_EN
          if (r_count < C_MIN) begin
            w_nxt       = S_PAD;
            w_count_nxt = r_count + 11'd1;
            w_crc_nxt   = crc32_byte(r_crc, B_PAD);
          end else begin
            w_nxt     = S_CRC;
            w_cnt_nxt = 3'd0;
          end
`else
          w_nxt     = S_CRC;
          w_cnt_nxt = 3'd0;
`endif
        end else if (w_acc) begin
          if (!LAST && (r_count == C_MAX)) begin
            // Overflow: the extra byte is replaced by /V/.
            w_nxt  = S_FLUSH;
            w_viol = 1'b1;
          end else begin
            w_nxt       = S_PAY;
            w_count_nxt = r_count + 11'd1;
            w_crc_nxt   = crc32_byte(r_crc, TXD_IN);
            w_last_nxt  = LAST;
          end
        end else begin
          // Underrun: source ran dry before LAST.
          w_nxt  = S_FLUSH;
          w_viol = 1'b1;
        end
      end
      S_PAD: begin
        if (r_count < C_MIN) begin
          w_nxt       = S_PAD;
          w_count_nxt = r_count + 11'd1;
          w_crc_nxt   = crc32_byte(r_crc, B_PAD);
        end else begin
          w_nxt     = S_CRC;
          w_cnt_nxt = 3'd0;
        end
      end
      S_CRC: begin
        if (r_cnt == 3'd3) begin
          w_nxt = S_EOPT;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_EOPT: begin
        w_nxt = S_EXTR;
      end
      S_EXTR: begin
        // A /R/ on even parity needs a second one so idle restarts on even.
        if (!r_par) begin
          w_nxt = S_EXTR;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (w_acc && LAST) begin
          w_nxt = S_EOPT;
        end else begin
          w_nxt = S_FLUSH;
        end
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  // Line symbol for the upcoming state, registered alongside it.
  always_comb begin
    w_txd_nxt = K_IDLE;
    w_txk_nxt = 1'b1;
    case (w_nxt)
      S_IDLE: begin
        if (w_par_nxt) begin
          w_txd_nxt = D_IDLE;
          w_txk_nxt = 1'b0;
        end else begin
          w_txd_nxt = K_IDLE;
          w_txk_nxt = 1'b1;
        end
      end
      S_START: begin
        w_txd_nxt = K_START;
        w_txk_nxt = 1'b1;
      end
      S_PRE: begin
        w_txd_nxt = B_PRE;
        w_txk_nxt = 1'b0;
      end
      S_SFD: begin
        w_txd_nxt = B_SFD;
        w_txk_nxt = 1'b0;
      end
      S_PAY: begin
        w_txd_nxt = TXD_IN;
        w_txk_nxt = 1'b0;
      end
      S_PAD: begin
        w_txd_nxt = B_PAD;
        w_txk_nxt = 1'b0;
      end
      S_CRC: begin
        w_txk_nxt = 1'b0;
        case (w_cnt_nxt[1:0])
          2'd0:    w_txd_nxt = w_crc_out[7:0];
          2'd1:    w_txd_nxt = w_crc_out[15:8];
          2'd2:    w_txd_nxt = w_crc_out[23:16];
          2'd3:    w_txd_nxt = w_crc_out[31:24];
          default: w_txd_nxt = w_crc_out[7:0];
        endcase
      end
      S_EOPT: begin
        w_txd_nxt = K_TERM;
        w_txk_nxt = 1'b1;
      end
      S_EXTR: begin
        w_txd_nxt = K_CARR;
        w_txk_nxt = 1'b1;
      end
      S_FLUSH: begin
        w_txk_nxt = 1'b1;
        if (w_viol) begin
          w_txd_nxt = K_VIOL;
        end else begin
          w_txd_nxt = K_CARR;
        end
      end
      default: begin
        w_txd_nxt = K_IDLE;
        w_txk_nxt = 1'b1;
      end
    endcase
  end

  // State, parity, line outputs and frame bookkeeping registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_par       <= 1'b0;
      r_txd       <= K_IDLE;
      r_txk       <= 1'b1;
      r_err       <= 1'b0;
      r_count     <= 11'd0;
      r_crc       <= CRC_INIT;
      r_cnt       <= 3'd0;
      r_last_seen <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_par       <= w_par_nxt;
      r_txd       <= w_txd_nxt;
      r_txk       <= w_txk_nxt;
      r_err       <= w_viol;
      r_count     <= w_count_nxt;
      r_crc       <= w_crc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_seen <= w_last_nxt;
    end
  end

  assign TXRDY = w_rdy;
  assign TXD   = r_txd;
  assign TXK   = r_txk;
  assign ERR   = r_err;
  assign BUSY  = (r_state != S_IDLE);
  assign STATE = r_state;

endmodule

// File: tb/tb_pkt_tx.sv
// tb_pkt_tx: self-checking bench for pkt_tx. A reference model builds the
// expected line stream ({ERR,TXK,TXD} per cycle) from frame-level rules and
// compares it with the captured stream. Honors PKT_TX_PAD_EN like the DUT.
module tb_pkt_tx;

  localparam int MAXC = 896;
  localparam int MINC = 60;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] TXD_IN;
  logic       TXVALID;
  logic       LAST;
  logic       TXRDY;
  logic [7:0] TXD;
  logic       TXK;
  logic       ERR;
  logic       BUSY;
  logic [3:0] STATE;

  pkt_tx #(.MAX_COUNT(MAXC), .MIN_COUNT(MINC)) dut (
    .CLK(CLK), .RST(RST), .TXD_IN(TXD_IN), .TXVALID(TXVALID), .LAST(LAST),
    .TXRDY(TXRDY), .TXD(TXD), .TXK(TXK), .ERR(ERR), .BUSY(BUSY), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic       bpar   = 1'b0;    // bench's own view of line parity
  logic [9:0] exp_q[$];
  logic [9:0] cap_q[$];
  logic [8:0] in_q[$];          // {last, byte}
  int         stall_at  = -1;
  int         stall_len = 0;

  task automatic step();
    logic r;
    r = RST;
    @(posedge CLK);
    if (r) bpar = 1'b0;
    else   bpar = ~bpar;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    TXVALID = 1'b0;
    LAST    = 1'b0;
    repeat (n) step();
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] d[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ d[i][b]) c = {1'b0, c[31:1]} ^ 32'hEDB8_8320;
        else                c = {1'b0, c[31:1]};
      end
    end
    return ~c;
  endfunction

  function automatic void exp_add(input logic k, input logic [7:0] d, input logic e);
    exp_q.push_back({e, k, d});
  endfunction

  // Idle filler before /S/: a launch from an even idle cycle waits one cycle.
  function automatic void model_prefix();
    if (bpar == 1'b0) exp_add(1'b0, 8'h50, 1'b0);
  endfunction

  function automatic void model_gap();
    exp_add(1'b1, 8'hBC, 1'b0);
    exp_add(1'b0, 8'h50, 1'b0);
  endfunction

  function automatic void model_head();
    exp_add(1'b1, 8'hFB, 1'b0);
    for (int i = 0; i < 6; i++) exp_add(1'b0, 8'h55, 1'b0);
    exp_add(1'b0, 8'hD5, 1'b0);
  endfunction

  // /T/ then /R/ (twice when the first /R/ is on even parity; /S/ index s is even).
  function automatic void model_tail(input int s);
    int f;
    exp_add(1'b1, 8'hFD, 1'b0);
    f = exp_q.size();
    exp_add(1'b1, 8'hF7, 1'b0);
    if (((f - s) % 2) == 0) exp_add(1'b1, 8'hF7, 1'b0);
  endfunction

  function automatic void model_good(input logic [7:0] pl[$]);
    logic [7:0]  body[$];
    logic [31:0] c;
    int          s;
    s = exp_q.size();
    model_head();
    body = pl;
`ifdef PKT_TX_PAD_EN
    while (body.size() < MINC) body.push_back(8'h00);
`endif
    foreach (body[i]) exp_add(1'b0, body[i], 1'b0);
    c = ref_crc(body);
    for (int i = 0; i < 4; i++) exp_add(1'b0, c[8*i +: 8], 1'b0);
    model_tail(s);
  endfunction

  function automatic void model_err(input logic [7:0] pl[$], input int good, input int flush_cycles);
    int s;
    s = exp_q.size();
    model_head();
    for (int i = 0; i < good; i++) exp_add(1'b0, pl[i], 1'b0);
    exp_add(1'b1, 8'hFE, 1'b1);
    for (int i = 1; i < flush_cycles; i++) exp_add(1'b1, 8'hF7, 1'b0);
    model_tail(s);
  endfunction

  function automatic void load_frame(input logic [7:0] pl[$]);
    foreach (pl[i]) in_q.push_back({(i == pl.size() - 1), pl[i]});
  endfunction

  function automatic void rand_frame(output logic [7:0] pl[$], input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
  endfunction

  // Drive in_q for exactly as many cycles as the model expects, then compare.
  task automatic run_and_check(input string name);
    int n, ptr, stall_left, idx;
    logic acc;
    n = exp_q.size();
    cap_q.delete();
    ptr = 0;
    stall_left = stall_len;
    for (int i = 0; i < n; i++) begin
      if ((ptr == stall_at) && (stall_left > 0)) begin
        TXVALID = 1'b0;
        LAST    = 1'b0;
        TXD_IN  = 8'($urandom_range(0, 255));
        stall_left--;
      end else if (ptr < in_q.size()) begin
        TXVALID = 1'b1;
        TXD_IN  = in_q[ptr][7:0];
        LAST    = in_q[ptr][8];
      end else begin
        TXVALID = 1'b0;
        LAST    = 1'b0;
      end
      acc = TXVALID && TXRDY;
      step();
      if (acc) ptr++;
      cap_q.push_back({ERR, TXK, TXD});
    end
    TXVALID = 1'b0;
    LAST    = 1'b0;
    idx = -1;
    for (int i = 0; i < n; i++) begin
      if (cap_q[i] !== exp_q[i]) begin
        idx = i;
        break;
      end
    end
    n_cmp++;
    if (idx >= 0) begin
      n_fail++;
      $display("FAIL %s stream: cycle %0d got {err,k,d}=%h required %h", name, idx, cap_q[idx], exp_q[idx]);
    end
    n_cmp++;
    if (ptr != in_q.size()) begin
      n_fail++;
      $display("FAIL %s consumed: got %0d bytes required %0d", name, ptr, in_q.size());
    end
    exp_q.delete();
    in_q.delete();
    stall_at  = -1;
    stall_len = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1; TXVALID = 1'b0; LAST = 1'b0; TXD_IN = 8'h00;
    repeat (3) step();
    n_cmp++; if (STATE !== 4'd0)  begin n_fail++; $display("FAIL reset_state: got %0d required 0", STATE); end
    n_cmp++; if (TXD !== 8'hBC)   begin n_fail++; $display("FAIL reset_txd: got %h required bc", TXD); end
    n_cmp++; if (TXK !== 1'b1)    begin n_fail++; $display("FAIL reset_txk: got %b required 1", TXK); end
    n_cmp++; if (ERR !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b required 0", ERR); end
    n_cmp++; if (BUSY !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b required 0", BUSY); end
    n_cmp++; if (TXRDY !== 1'b0)  begin n_fail++; $display("FAIL reset_txrdy: got %b required 0", TXRDY); end
    RST = 1'b0;
    step();
    n_cmp++; if ({TXK, TXD} !== 9'h050) begin n_fail++; $display("FAIL idle_odd: got %h required 050", {TXK, TXD}); end
    step();
    n_cmp++; if ({TXK, TXD} !== 9'h1BC) begin n_fail++; $display("FAIL idle_even: got %h required 1bc", {TXK, TXD}); end
  endtask

  task automatic test_frame64();
    logic [7:0] pl[$];
    idle_cycles($urandom_range(0, 3));
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    load_frame(pl);
    model_prefix(); model_good(pl); exp_add(1'b1, 8'hBC, 1'b0);
    run_and_check("frame64");
  endtask

  task automatic test_random_frames();
    logic [7:0] pl[$];
    for (int f = 0; f < 5; f++) begin
      idle_cycles($urandom_range(0, 3));
      rand_frame(pl, $urandom_range(1, 150));
      load_frame(pl);
      model_prefix(); model_good(pl); exp_add(1'b1, 8'hBC, 1'b0);
      run_and_check("random_frame");
    end
  endtask

  task automatic test_pad();
    logic [7:0] pl[$];
    idle_cycles($urandom_range(0, 3));
    rand_frame(pl, 10);
    load_frame(pl);
    model_prefix(); model_good(pl); exp_add(1'b1, 8'hBC, 1'b0);
    run_and_check("short10");
    idle_cycles(1);
    rand_frame(pl, 1);
    load_frame(pl);
    model_prefix(); model_good(pl); exp_add(1'b1, 8'hBC, 1'b0);
    run_and_check("short1");
  endtask

  task automatic test_underrun();
    logic [7:0] pl[$];
    int k, len;
    idle_cycles($urandom_range(0, 3));
    rand_frame(pl, 100);
    load_frame(pl);
    stall_at = 20; stall_len = $urandom_range(1, 4);
    model_prefix(); model_err(pl, 20, (stall_len - 1) + 80); exp_add(1'b1, 8'hBC, 1'b0);
    run_and_check("underrun20");
    idle_cycles($urandom_range(0, 3));
    len = $urandom_range(2, 70);
    k   = $urandom_range(1, len - 1);
    rand_frame(pl, len);
    load_frame(pl);
    stall_at = k; stall_len = $urandom_range(1, 3);
    model_prefix(); model_err(pl, k, (stall_len - 1) + (len - k)); exp_add(1'b1, 8'hBC, 1'b0);
    run_and_check("underrun_rand");
  endtask

  task automatic test_overflow();
    logic [7:0] pl[$];
    idle_cycles($urandom_range(0, 3));
    rand_frame(pl, MAXC + 4);
    load_frame(pl);
    model_prefix(); model_err(pl, MAXC, (MAXC + 4) - (MAXC + 1)); exp_add(1'b1, 8'hBC, 1'b0);
    run_and_check("overflow");
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl[$];
    int ptr;
    logic acc, found;
    idle_cycles(1);
    rand_frame(pl, 40);
    ptr = 0;
    found = 1'b0;
    for (int i = 0; (i < 300) && !found; i++) begin
      if (ptr < 40) begin
        TXVALID = 1'b1; TXD_IN = pl[ptr]; LAST = (ptr == 39);
      end else begin
        TXVALID = 1'b0; LAST = 1'b0;
      end
      acc = TXVALID && TXRDY;
      step();
      if (acc) ptr++;
      if (STATE == 4'd6) found = 1'b1;
    end
    TXVALID = 1'b0; LAST = 1'b0;
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL reach_crc: got %b required 1", found); end
    RST = 1'b1;
    step();
    n_cmp++; if ({TXK, TXD} !== 9'h1BC) begin n_fail++; $display("FAIL rst_mid_txd: got %h required 1bc", {TXK, TXD}); end
    n_cmp++; if (STATE !== 4'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d required 0", STATE); end
    n_cmp++; if (BUSY !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_busy: got %b required 0", BUSY); end
    n_cmp++; if (ERR !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_err: got %b required 0", ERR); end
    RST = 1'b0;
    step();
    n_cmp++; if ({TXK, TXD} !== 9'h050) begin n_fail++; $display("FAIL rst_mid_idle: got %h required 050", {TXK, TXD}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pl[$];
    idle_cycles($urandom_range(0, 3));
    model_prefix();
    for (int f = 0; f < 3; f++) begin
      rand_frame(pl, $urandom_range(1, 80));
      load_frame(pl);
      if (f != 0) model_gap();
      model_good(pl);
    end
    exp_add(1'b1, 8'hBC, 1'b0);
    run_and_check("back_to_back");
  endtask

  initial begin
    test_reset();
    test_frame64();
    test_random_frames();
    test_pad();
    test_underrun();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_tx.md
PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 Parameter MAX_COUNT, default 896: maximum payload bytes (excluding CRC) per frame.
REQ-002 Parameter MIN_COUNT, default 60: minimum payload bytes after padding.
REQ-003 CLK  input  1  sole clock; all logic on posedge CLK.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 TXD_IN  input  8  payload byte from the source.
REQ-006 TXVALID  input  1  TXD_IN valid; LAST qualifies it.
REQ-007 LAST  input  1  TXD_IN is the final payload byte of the frame.
REQ-008 TXRDY  output  1  combinational; a byte is accepted on a cycle with TXVALID && TXRDY.
REQ-009 TXD  output  8  registered line byte or K-code.
REQ-010 TXK  output  1  registered; TXD is a K character.
REQ-011 ERR  output  1  registered one-cycle pulse on underrun or overflow.
REQ-012 BUSY  output  1  high in every state except Idle.
REQ-013 STATE  output  4  current state encoding.

Function
REQ-014 States (STATE value): Idle 0, Start 1, Preamble 2, Sfd 3, Payload 4, Pad 5, Crc 6, EopT 7, ExtR 8, Flush 9; undefined encodings go to Idle next cycle.
REQ-015 Each state's TXD/TXK output appears on the cycle the state is current.
REQ-016 Parity bit toggles every cycle; it is 0 on the first cycle after reset.
REQ-017 Idle: even parity outputs K28.5 (0xBC, TXK=1); odd parity outputs D16.2 (0x50, TXK=0).
REQ-018 Idle -> Start only when TXVALID=1 on an odd-parity cycle; otherwise remain in Idle. /S/ always lands on even parity.
REQ-019 Start outputs /S/ K27.7 (0xFB, TXK=1), then goes to Preamble.
REQ-020 Preamble outputs 0x55 for exactly 6 cycles, then goes to Sfd.
REQ-021 Sfd outputs 0xD5.
REQ-022 TXRDY is 1 in Sfd and in Payload; it is 0 everywhere else except Flush.
REQ-023 A byte accepted on cycle n is output in Payload on cycle n+1.
REQ-024 Payload length counter is 11 bits; it clears in Start and increments on each accepted byte.
REQ-025 Accepting the byte with LAST=1 sets the next state to Pad if count < MIN_COUNT, otherwise to Crc.
REQ-026 Pad outputs 0x00 and counts until MIN_COUNT bytes total have been sent, then goes to Crc.
REQ-027 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) covers payload and pad bytes only.
REQ-028 Crc outputs the 4 CRC bytes least-significant byte first, then goes to EopT.
REQ-029 EopT outputs /T/ K29.7 (0xFD, TXK=1).
REQ-030 ExtR outputs /R/ K23.7 (0xF7, TXK=1). Emit one /R/; emit a second /R/ if the first lands on even parity. Idle then resumes on even parity.
REQ-031 Underrun: in Sfd or Payload with LAST not yet accepted, TXVALID=0 -> output /V/ K30.7 (0xFE, TXK=1) next cycle, pulse ERR, go to Flush.
REQ-032 Overflow: accepting byte MAX_COUNT+1 without LAST -> /V/ instead of that byte, pulse ERR, go to Flush.
REQ-033 Flush: TXRDY=1, TXD/TXK output /R/, discard bytes; on an accepted LAST go to EopT.
REQ-034 When underrun and overflow occur on the same cycle, report a single ERR pulse.
REQ-035 TXVALID in Idle on even parity waits exactly one cycle before Start.

Reset
REQ-036 On RST: state=Idle, parity=0, TXD=0xBC, TXK=1, ERR=0, count=0, CRC=0xFFFFFFFF.
REQ-037 RST asserted mid-frame aborts the frame immediately; no /T/ or /V/ is emitted and K28.5 appears on the next cycle.

Configuration
REQ-038 Macro PKT_TX_PAD_EN defined: Pad state is active as specified in REQ-025/REQ-026.
REQ-039 PKT_TX_PAD_EN undefined: Pad is never entered, LAST always leads to Crc, and short frames are sent unpadded.

Verification
REQ-040 Frame of 64 bytes 0x00..0x3F -> S, 6x55, D5, 64 data bytes, 4 CRC bytes, FD, F7(+F7 if needed); idle resumes BC on even parity.
REQ-041 Frame of 10 bytes with PKT_TX_PAD_EN -> 50 bytes of 0x00 pad and CRC over 60 bytes; without the macro -> no pad and CRC over 10 bytes.
REQ-042 TXVALID drops after byte 20 of 100 -> FE, ERR pulse, F7s until LAST accepted, then FD.
REQ-043 897 bytes without LAST -> byte 897 replaced by FE, ERR=1 for one cycle, Flush.
REQ-044 RST asserted during Crc -> next cycle TXD=0xBC, TXK=1, STATE=0, BUSY=0.
REQ-045 Back-to-back frames with TXVALID held high -> each /S/ appears only on even parity after at least one BC,50 pair.
